seq_controller: RTL and testbench

Record/playback controller for the button sequencer. Consumes the one-cycle pulses produced by the per-button debouncers, records the order of button presses into a small internal memory, and plays the sequence back on four LEDs with fixed on/gap timing. Sits between the debouncer bank and the LED outputs at top level.

---
 rtl/seq_pkg.sv | 31 +++
 rtl/seq_mem.sv | 40 ++++
 rtl/seq_controller.sv | 215 +++++++++++++++++++++
 tb/tb_seq_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seq_pkg                                                     |
// | Purpose : Shared types and helpers for the record/playback sequencer: |
// |           FSM state encoding, button count, 2-bit entry index type,   |
// |           and the index-to-one-hot LED decode.                        |
// | Ports   : none (package)                                              |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package seq_pkg;

  localparam int NUM_BTNS = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RECORD   = 2'd1,
    S_PLAY_ON  = 2'd2,
    S_PLAY_GAP = 2'd3
  } state_t;

  function automatic logic [NUM_BTNS-1:0] idx2onehot(input idx_t i_idx);
    logic [NUM_BTNS-1:0] r_oh;
    r_oh = '0;
    r_oh[i_idx] = 1'b1;
    return r_oh;
  endfunction

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seq_mem                                                     |
// | Purpose : DEPTH x 2-bit sequence store. Synchronous write,            |
// |           combinational read, deliberately not reset (the recorded    |
// |           count qualifies which entries are valid).                   |
// | Ports   : clk      - system clock                                     |
// |           i_we     - write enable                                     |
// |           i_waddr  - write address                                    |
// |           i_wdata  - 2-bit button index to store                      |
// |           i_raddr  - read address                                     |
// |           o_rdata  - entry at i_raddr (combinational)                 |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module seq_mem
  import seq_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  idx_t                  i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output idx_t                  o_rdata
);

  idx_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : seq_mem
`default_nettype wire

// File: rtl/seq_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seq_controller                                              |
// | Purpose : Records the order of debounced button presses and plays it  |
// |           back on four one-hot LEDs with fixed on/gap timing.         |
// | Config  : SEQ_LOOP_EN - when defined, playback wraps to the first     |
// |           entry after the last gap and repeats until aborted; when    |
// |           undefined, playback is a single pass back to IDLE.          |
// | Ports   : clk        - system clock                                   |
// |           rst        - asynchronous active-high reset                 |
// |           rec_pulse  - record start/stop pulse                        |
// |           play_pulse - play start/abort pulse                         |
// |           btn_pulse  - per-button press pulses                        |
// |           leds       - one-hot LED drive (registered)                 |
// |           recording  - high in RECORD                                 |
// |           playing    - high in PLAY_ON / PLAY_GAP                     |
// |           full       - count == DEPTH                                 |
// |           count      - number of stored entries                       |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module seq_controller
  import seq_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int TIMER_WIDTH = 24,
  parameter int STEP_CLKS   = 12000000 - 1,
  parameter int GAP_CLKS    = 2400000 - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rec_pulse,
  input  logic                  play_pulse,
  input  logic [NUM_BTNS-1:0]   btn_pulse,
  output logic [NUM_BTNS-1:0]   leds,
  output logic                  recording,
  output logic                  playing,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [TIMER_WIDTH-1:0] c_step_end = TIMER_WIDTH'(STEP_CLKS);
  localparam logic [TIMER_WIDTH-1:0] c_gap_end  = TIMER_WIDTH'(GAP_CLKS);
  localparam logic [ADDR_WIDTH:0]    c_depth    = (ADDR_WIDTH+1)'(DEPTH);

  state_t                  r_state;
  logic [TIMER_WIDTH-1:0]  r_timer;
  logic [ADDR_WIDTH-1:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]     r_count;
  logic [NUM_BTNS-1:0]     r_leds;
  logic                    r_recording;
  logic                    r_playing;
  logic                    r_full;

  state_t                  w_state_nxt;
  logic [TIMER_WIDTH-1:0]  w_timer_nxt;
  logic [ADDR_WIDTH-1:0]   w_rd_ptr_nxt;
  logic [ADDR_WIDTH:0]     w_count_nxt;
  logic [NUM_BTNS-1:0]     w_leds_nxt;
  logic                    w_we;
  idx_t                    w_btn_idx;
  idx_t                    w_rdata;
  logic                    w_last;

  // Lowest set bit wins when several buttons pulse together.
  always_comb begin
    w_btn_idx = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (btn_pulse[i]) begin
        w_btn_idx = idx_t'(i);
      end
    end
  end

  assign w_last = ({1'b0, r_rd_ptr} == (r_count - 1'b1));

  // Read at the next pointer so the LED register can be loaded on the
  // same edge that enters or advances PLAY_ON.
  seq_mem #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_count[ADDR_WIDTH-1:0]),
    .i_wdata (w_btn_idx),
    .i_raddr (w_rd_ptr_nxt),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_leds      <= '0;
      r_recording <= 1'b0;
      r_playing   <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_leds      <= w_leds_nxt;
      r_recording <= (w_state_nxt == S_RECORD);
      r_playing   <= (w_state_nxt == S_PLAY_ON) || (w_state_nxt == S_PLAY_GAP);
      r_full      <= (w_count_nxt == c_depth);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_leds_nxt   = r_leds;
    w_we         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_leds_nxt = '0;
        if (rec_pulse) begin
          w_state_nxt  = S_RECORD;
          w_count_nxt  = '0;
          w_timer_nxt  = '0;
          w_rd_ptr_nxt = '0;
        end else if (play_pulse && (r_count != '0)) begin
          w_state_nxt  = S_PLAY_ON;
          w_timer_nxt  = '0;
          w_rd_ptr_nxt = '0;
        end
      end

      S_RECORD: begin
        if (rec_pulse) begin
          w_state_nxt  = S_IDLE;
          w_leds_nxt   = '0;
          w_timer_nxt  = '0;
          w_rd_ptr_nxt = '0;
        end else if (play_pulse) begin
          w_state_nxt  = (r_count != '0) ? S_PLAY_ON : S_IDLE;
          w_leds_nxt   = '0;
          w_timer_nxt  = '0;
          w_rd_ptr_nxt = '0;
        end else if ((btn_pulse != '0) && (r_count != c_depth)) begin
          w_we        = 1'b1;
          w_count_nxt = r_count + 1'b1;
          w_leds_nxt  = idx2onehot(w_btn_idx);
        end
      end

      S_PLAY_ON: begin
        if (play_pulse) begin
          w_state_nxt  = S_IDLE;
          w_leds_nxt   = '0;
          w_timer_nxt  = '0;
          w_rd_ptr_nxt = '0;
        end else if (r_timer == c_step_end) begin
          w_state_nxt = S_PLAY_GAP;
          w_leds_nxt  = '0;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      S_PLAY_GAP: begin
        w_leds_nxt = '0;
        if (play_pulse) begin
          w_state_nxt  = S_IDLE;
          w_timer_nxt  = '0;
          w_rd_ptr_nxt = '0;
        end else if (r_timer == c_gap_end) begin
          w_timer_nxt = '0;
          if (w_last) begin
            w_rd_ptr_nxt = '0;
`ifdef SEQ_LOOP_EN
            w_state_nxt  = S_PLAY_ON;
`else
            w_state_nxt  = S_IDLE;
`endif
          end else begin
            w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            w_state_nxt  = S_PLAY_ON;
          end
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_leds_nxt   = '0;
        w_timer_nxt  = '0;
        w_rd_ptr_nxt = '0;
      end
    endcase

    // Whether entering, advancing or staying, PLAY_ON shows the entry
    // under the pointer it will hold after this edge.
    if (w_state_nxt == S_PLAY_ON) begin
      w_leds_nxt = idx2onehot(w_rdata);
    end
  end

  assign leds      = r_leds;
  assign recording = r_recording;
  assign playing   = r_playing;
  assign full      = r_full;
  assign count     = r_count;

endmodule : seq_controller
`default_nettype wire

// File: tb/tb_seq_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_seq_controller                                           |
// | Purpose : Directed self-checking bench for seq_controller with        |
// |           DEPTH=4, STEP_CLKS=3, GAP_CLKS=1. Honors SEQ_LOOP_EN.       |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_seq_controller;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rec_pulse = 1'b0;
  logic       play_pulse = 1'b0;
  logic [3:0] btn_pulse = 4'b0;
  logic [3:0] leds;
  logic       recording;
  logic       playing;
  logic       full;
  logic [AW:0] count;

  int n_vec = 0;
  int n_err = 0;
  int exp_idx [4];

  seq_controller #(
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (AW),
    .TIMER_WIDTH (24),
    .STEP_CLKS   (3),
    .GAP_CLKS    (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rec_pulse  (rec_pulse),
    .play_pulse (play_pulse),
    .btn_pulse  (btn_pulse),
    .leds       (leds),
    .recording  (recording),
    .playing    (playing),
    .full       (full),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic rec, input logic play, input logic [3:0] btn);
    rec_pulse  = rec;
    play_pulse = play;
    btn_pulse  = btn;
    tick();
    rec_pulse  = 1'b0;
    play_pulse = 1'b0;
    btn_pulse  = 4'b0;
  endtask

  // Assumes the play pulse edge has just been taken: 4 lit + 2 dark per step.
  task automatic check_play(input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 6; c++) begin
        if (!(i == 0 && c == 0)) tick();
        chk($sformatf("play_led[%0d.%0d]", i, c), {28'b0, leds},
            (c < 4) ? (32'd1 << exp_idx[i]) : 32'd0);
        chk($sformatf("play_act[%0d.%0d]", i, c), {31'b0, playing}, 32'd1);
      end
    end
    tick();
`ifdef SEQ_LOOP_EN
    chk("loop_led", {28'b0, leds}, 32'd1 << exp_idx[0]);
    chk("loop_act", {31'b0, playing}, 32'd1);
    pulse(1'b0, 1'b1, 4'b0);
`endif
    chk("end_act", {31'b0, playing}, 32'd0);
    chk("end_led", {28'b0, leds}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    #12;
    rst = 1'b0;
    tick();
    chk("rst_led", {28'b0, leds}, 0);
    chk("rst_rec", {31'b0, recording}, 0);
    chk("rst_play", {31'b0, playing}, 0);
    chk("rst_full", {31'b0, full}, 0);
    chk("rst_cnt", {29'b0, count}, 0);

    // Empty play is ignored; rec wins over play.
    pulse(1'b0, 1'b1, 4'b0);
    chk("empty_play", {31'b0, playing}, 0);
    chk("empty_led", {28'b0, leds}, 0);
    pulse(1'b1, 1'b1, 4'b0);
    chk("both_rec", {31'b0, recording}, 1);
    chk("both_play", {31'b0, playing}, 0);
    pulse(1'b1, 1'b0, 4'b0);
    chk("rec_exit", {31'b0, recording}, 0);

    // Record 0001, 0100, 0010 then play.
    pulse(1'b1, 1'b0, 4'b0);
    chk("rec_on", {31'b0, recording}, 1);
    chk("rec_led0", {28'b0, leds}, 0);
    chk("rec_cnt0", {29'b0, count}, 0);
    pulse(1'b0, 1'b0, 4'b0001);
    chk("rec_cnt1", {29'b0, count}, 1);
    chk("rec_led1", {28'b0, leds}, 4'b0001);
    pulse(1'b0, 1'b0, 4'b0100);
    chk("rec_led2", {28'b0, leds}, 4'b0100);
    pulse(1'b0, 1'b0, 4'b0010);
    chk("rec_cnt3", {29'b0, count}, 3);
    chk("rec_led3", {28'b0, leds}, 4'b0010);
    chk("rec_full3", {31'b0, full}, 0);
    pulse(1'b1, 1'b0, 4'b0);
    chk("rec_off", {31'b0, recording}, 0);
    exp_idx[0] = 0; exp_idx[1] = 2; exp_idx[2] = 1;
    pulse(1'b0, 1'b1, 4'b0);
    check_play(3);

    // Overflow: fifth press dropped; exit directly from RECORD into play.
    pulse(1'b1, 1'b0, 4'b0);
    pulse(1'b0, 1'b0, 4'b1000);
    pulse(1'b0, 1'b0, 4'b0001);
    pulse(1'b0, 1'b0, 4'b0010);
    chk("ovf_full3", {31'b0, full}, 0);
    pulse(1'b0, 1'b0, 4'b0100);
    chk("ovf_cnt4", {29'b0, count}, 4);
    chk("ovf_full4", {31'b0, full}, 1);
    pulse(1'b0, 1'b0, 4'b1000);
    chk("ovf_cnt5", {29'b0, count}, 4);
    chk("ovf_led5", {28'b0, leds}, 4'b0100);
    exp_idx[0] = 3; exp_idx[1] = 0; exp_idx[2] = 1; exp_idx[3] = 2;
    pulse(1'b0, 1'b1, 4'b0);
    chk("ovf_rec_off", {31'b0, recording}, 0);
    check_play(4);

    // Priority encode; press coincident with exit is not stored.
    pulse(1'b1, 1'b0, 4'b0);
    pulse(1'b0, 1'b0, 4'b1010);
    chk("pri_led", {28'b0, leds}, 4'b0010);
    pulse(1'b1, 1'b0, 4'b0001);
    chk("pri_cnt", {29'b0, count}, 1);
    exp_idx[0] = 1;
    pulse(1'b0, 1'b1, 4'b0);
    check_play(1);

    // Abort during the second PLAY_ON cycle.
    pulse(1'b0, 1'b1, 4'b0);
    chk("abt_led0", {28'b0, leds}, 4'b0010);
    tick();
    pulse(1'b0, 1'b1, 4'b0);
    chk("abt_led", {28'b0, leds}, 0);
    chk("abt_play", {31'b0, playing}, 0);
    chk("abt_cnt", {29'b0, count}, 1);

    // Async reset in the middle of PLAY_GAP.
    pulse(1'b0, 1'b1, 4'b0);
    for (int k = 0; k < 4; k++) tick();
    chk("gap_play", {31'b0, playing}, 1);
    chk("gap_led", {28'b0, leds}, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_play", {31'b0, playing}, 0);
    chk("arst_cnt", {29'b0, count}, 0);
    chk("arst_led", {28'b0, leds}, 0);
    chk("arst_full", {31'b0, full}, 0);
    tick();
    rst = 1'b0;
    tick();
    pulse(1'b0, 1'b1, 4'b0);
    chk("post_play", {31'b0, playing}, 0);
    chk("post_cnt", {29'b0, count}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no end, expected summary");
    $fatal(1);
  end

endmodule : tb_seq_controller
`default_nettype wire
